// File: rtl/mem_arbiter_if.sv
// Bundle of cache-miss request, memory access and completion signals around mem_arbiter.
// The arbiter takes the slave view; caches plus main memory together take the master view.
interface mem_arbiter_if;
   logic        i_req;
   logic [15:0] i_addr;
   logic        d_req;
   logic        d_wr;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic [15:0] mem_rdata;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        i_done;
   logic        d_done;
   logic [15:0] rdata;
   logic        stall_if;
   logic        stall_mem;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      output mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, rdata, stall_if, stall_mem
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata,
      input  mem_en, mem_wr, mem_addr, mem_wdata, i_done, d_done, rdata, stall_if, stall_mem
   );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction- and data-cache misses onto one fixed-latency memory port.
// Define ARB_ROUND_ROBIN_EN to break IDLE ties against the last owner instead of always favouring data.
module mem_arbiter #(
   parameter int unsigned MEM_LAT = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic        done;
   logic        grant;
   logic        d_wins;
   logic        mem_en_q;
   logic        mem_wr_q;
   logic [15:0] mem_addr_q;
   logic [15:0] mem_wdata_q;

   // The counter holds during the strobe cycle, so done lands MEM_LAT cycles after mem_en.
   assign done  = (state != IDLE) && (cnt == 4'd0);
   assign grant = (state_nxt != IDLE) && ((state == IDLE) || done);

`ifdef ARB_ROUND_ROBIN_EN
   logic last_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_d <= 1'b1;
      end else if (grant) begin
         last_d <= (state_nxt == D_BUSY);
      end
   end

   always_comb begin
      d_wins = bus.d_req;
      if (bus.d_req && bus.i_req) begin
         d_wins = !last_d;
      end
   end
`else
   always_comb begin
      d_wins = bus.d_req;
   end
`endif

   // NOTE: clocked state uses <= so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // NOTE: a default assignment ahead of the case keeps every path driven, so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (d_wins) begin
               state_nxt = D_BUSY;
            end else if (bus.i_req) begin
               state_nxt = I_BUSY;
            end
         end
         // On completion only the other requester may be granted; the owner's req is ignored.
         I_BUSY: begin
            if (done) begin
               state_nxt = bus.d_req ? D_BUSY : IDLE;
            end
         end
         D_BUSY: begin
            if (done) begin
               state_nxt = bus.i_req ? I_BUSY : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt         <= 4'd0;
         mem_en_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= 16'h0000;
         mem_wdata_q <= 16'h0000;
      end else begin
         mem_en_q <= grant;
         if (grant) begin
            cnt <= CNT_LOAD;
            if (state_nxt == D_BUSY) begin
               mem_addr_q  <= bus.d_addr;
               mem_wr_q    <= bus.d_wr;
               mem_wdata_q <= bus.d_wdata;
            end else begin
               mem_addr_q  <= bus.i_addr;
               mem_wr_q    <= 1'b0;
               mem_wdata_q <= 16'h0000;
            end
         end else if ((state != IDLE) && !mem_en_q && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   always_comb begin
      bus.mem_en    = mem_en_q;
      bus.mem_wr    = mem_wr_q;
      bus.mem_addr  = mem_addr_q;
      bus.mem_wdata = mem_wdata_q;
      bus.i_done    = done && (state == I_BUSY);
      bus.d_done    = done && (state == D_BUSY);
      bus.rdata     = bus.mem_rdata;
      bus.stall_if  = bus.i_req && !(done && (state == I_BUSY));
      bus.stall_mem = bus.d_req && !(done && (state == D_BUSY));
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model checked every cycle,
// plus directed scenarios with hand-computed cycle latencies.
module tb_mem_arbiter;
   localparam int MEM_LAT = 4;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   mem_arbiter_if bus();

   mem_arbiter #(.MEM_LAT(MEM_LAT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory read data changes every cycle so rdata must follow it combinationally.
   always begin
      @(posedge clk);
      #1;
      bus.mem_rdata = 16'h5A00 ^ 16'(cyc * 37);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Model: owner 0 = none, 1 = instruction, 2 = data; a transaction started in cycle s
   // strobes in s and completes in s + MEM_LAT.
   int          owner = 0;
   int          start = 0;
   int          nxt;
   logic        m_last_d = 1'b1;
   logic [15:0] m_addr, m_wdata;
   logic        m_wr;
   logic        busy, done_e;
   int          last_en = -1;
   logic [15:0] en_addr, en_wdata;
   logic        en_wr;
   int          i_done_cnt = 0;
   int          d_done_cnt = 0;

   always @(negedge clk) begin
      if (!rst) begin
         check("rst mem_en", bus.mem_en, 1'b0);
         check("rst mem_wr", bus.mem_wr, 1'b0);
         check("rst mem_addr", bus.mem_addr, 16'h0000);
         check("rst mem_wdata", bus.mem_wdata, 16'h0000);
         check("rst i_done", bus.i_done, 1'b0);
         check("rst d_done", bus.d_done, 1'b0);
         owner    = 0;
         m_last_d = 1'b1;
      end else begin
         busy   = (owner != 0);
         done_e = busy && (cyc == start + MEM_LAT);
         check("mem_en", bus.mem_en, busy && (cyc == start));
         check("i_done", bus.i_done, done_e && (owner == 1));
         check("d_done", bus.d_done, done_e && (owner == 2));
         check("stall_if", bus.stall_if, bus.i_req && !(done_e && (owner == 1)));
         check("stall_mem", bus.stall_mem, bus.d_req && !(done_e && (owner == 2)));
         if (busy) begin
            check("mem_addr", bus.mem_addr, m_addr);
            check("mem_wr", bus.mem_wr, m_wr);
            check("mem_wdata", bus.mem_wdata, m_wdata);
         end
         if (done_e) check("rdata", bus.rdata, bus.mem_rdata);

         if (bus.mem_en) begin
            last_en  = cyc;
            en_addr  = bus.mem_addr;
            en_wr    = bus.mem_wr;
            en_wdata = bus.mem_wdata;
         end
         if (bus.i_done) i_done_cnt++;
         if (bus.d_done) d_done_cnt++;

         nxt = owner;
         if (done_e) begin
            nxt = 0;
            if (owner == 1 && bus.d_req) nxt = 2;
            if (owner == 2 && bus.i_req) nxt = 1;
         end else if (!busy) begin
            if (bus.d_req && bus.i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
               nxt = m_last_d ? 1 : 2;
`else
               nxt = 2;
`endif
            end else if (bus.d_req) begin
               nxt = 2;
            end else if (bus.i_req) begin
               nxt = 1;
            end
         end
         if ((done_e || !busy) && nxt != 0) begin
            start    = cyc + 1;
            m_last_d = (nxt == 2);
            if (nxt == 2) begin
               m_addr  = bus.d_addr;
               m_wr    = bus.d_wr;
               m_wdata = bus.d_wdata;
            end else begin
               m_addr  = bus.i_addr;
               m_wr    = 1'b0;
               m_wdata = 16'h0000;
            end
         end
         owner = nxt;
      end
   end

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_done(input bit is_d, input string name, output int at);
      at = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (is_d ? bus.d_done : bus.i_done) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: no done pulse within 40 cycles, required one", name);
      end
   endtask

   int t0, at, at_i, at_d, rel, cnt_snap;

   initial begin
      rst           = 1'b0;
      bus.i_req     = 1'b0;
      bus.i_addr    = 16'h0000;
      bus.d_req     = 1'b0;
      bus.d_wr      = 1'b0;
      bus.d_addr    = 16'h0000;
      bus.d_wdata   = 16'h0000;
      bus.mem_rdata = 16'h0000;
      tick(3);
      rst = 1'b1;
      tick(2);

      // Single instruction fetch
      t0 = cyc;
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h0040;
      wait_done(0, "fetch i_done", at);
      check("fetch en cycle", last_en - t0, 1);
      check("fetch en addr", en_addr, 16'h0040);
      check("fetch i_done cycle", at - t0, 5);
      tick();
      bus.i_req = 1'b0;
      tick(2);

      // Data write; inputs change mid-transaction and must not disturb the access
      t0 = cyc;
      cnt_snap    = i_done_cnt;
      bus.d_req   = 1'b1;
      bus.d_wr    = 1'b1;
      bus.d_addr  = 16'h1000;
      bus.d_wdata = 16'hBEEF;
      tick(2);
      bus.d_addr  = 16'h2222;
      bus.d_wdata = 16'h0000;
      bus.d_wr    = 1'b0;
      wait_done(1, "write d_done", at);
      check("write en addr", en_addr, 16'h1000);
      check("write en wr", en_wr, 1'b1);
      check("write en wdata", en_wdata, 16'hBEEF);
      check("write d_done cycle", at - t0, 5);
      check("write no i_done", i_done_cnt - cnt_snap, 0);
      tick();
      bus.d_req = 1'b0;
      tick(2);

      // Simultaneous requests
      t0 = cyc;
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h0300;
      bus.d_req  = 1'b1;
      bus.d_wr   = 1'b0;
      bus.d_addr = 16'h0400;
`ifdef ARB_ROUND_ROBIN_EN
      wait_done(0, "tie i_done", at_i);
      tick();
      bus.i_req = 1'b0;
      wait_done(1, "tie d_done", at_d);
      check("tie en addr", en_addr, 16'h0400);
      check("tie i_done cycle", at_i - t0, 5);
      check("tie d_done cycle", at_d - t0, 10);
      tick();
      bus.d_req = 1'b0;
`else
      wait_done(1, "tie d_done", at_d);
      tick();
      bus.d_req = 1'b0;
      wait_done(0, "tie i_done", at_i);
      check("tie d_done cycle", at_d - t0, 5);
      check("tie i en cycle", last_en - t0, 6);
      check("tie en addr", en_addr, 16'h0300);
      check("tie i_done cycle", at_i - t0, 10);
      tick();
      bus.i_req = 1'b0;
`endif
      tick(2);

      // One-cycle request pulse still completes, then no re-grant
      t0 = cyc;
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h0777;
      tick();
      bus.i_req = 1'b0;
      wait_done(0, "pulse i_done", at);
      check("pulse i_done cycle", at - t0, 5);
      tick(3);
      check("pulse no regrant", last_en - t0, 1);

      // Data request arriving during an instruction access is granted back-to-back
      t0 = cyc;
      bus.i_req  = 1'b1;
      bus.i_addr = 16'h0123;
      tick(2);
      bus.d_req   = 1'b1;
      bus.d_wr    = 1'b1;
      bus.d_addr  = 16'h0456;
      bus.d_wdata = 16'h1234;
      wait_done(0, "chain i_done", at_i);
      check("chain i_done cycle", at_i - t0, 5);
      tick();
      bus.i_req = 1'b0;
      wait_done(1, "chain d_done", at_d);
      check("chain d en cycle", last_en - t0, 6);
      check("chain d_done cycle", at_d - t0, 10);
      tick();
      bus.d_req = 1'b0;
      tick(2);

      // Reset in the third cycle of a data access
      t0 = cyc;
      cnt_snap   = d_done_cnt;
      bus.d_req  = 1'b1;
      bus.d_wr   = 1'b0;
      bus.d_addr = 16'h0ABC;
      tick(3);
      rst = 1'b0;
      #1;
      check("areset mem_en", bus.mem_en, 1'b0);
      check("areset mem_addr", bus.mem_addr, 16'h0000);
      check("areset d_done", bus.d_done, 1'b0);
      check("areset stall_mem", bus.stall_mem, 1'b1);
      tick(2);
      rst = 1'b1;
      rel = cyc;
      check("areset no d_done", d_done_cnt - cnt_snap, 0);
      wait_done(1, "rerun d_done", at);
      check("rerun en cycle", last_en - rel, 1);
      check("rerun en addr", en_addr, 16'h0ABC);
      check("rerun d_done cycle", at - rel, 5);
      tick();
      bus.d_req = 1'b0;
      tick(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: MEM_LAT, 4, fixed main-memory read/write latency in cycles, legal range 2..15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 i_req  input  1  instruction-cache miss request, held high until i_done.
REQ-005 i_addr  input  16  instruction fill address.
REQ-006 d_req  input  1  data-cache miss/writeback request, held high until d_done.
REQ-007 d_wr  input  1  1 = data write, 0 = data read.
REQ-008 d_addr  input  16  data address.
REQ-009 d_wdata  input  16  data write value.
REQ-010 mem_rdata  input  16  memory read data, valid MEM_LAT cycles after mem_en.
REQ-011 mem_en  output  1  one-cycle memory access strobe.
REQ-012 mem_wr  output  1  write qualifier for mem_en.
REQ-013 mem_addr, mem_wdata  output  16 each  registered access address and data.
REQ-014 i_done, d_done  output  1 each  one-cycle completion pulse to the owning requester.
REQ-015 rdata  output  16  equals mem_rdata, meaningful only when i_done or d_done is high.
REQ-016 stall_if, stall_mem  output  1 each  pipeline freeze for the fetch and memory stages.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, I_BUSY, D_BUSY.
REQ-018 IDLE: d_req high -> D_BUSY; else i_req high -> I_BUSY; else stay. Data has fixed priority.
REQ-019 On entry to a BUSY state, mem_en SHALL be high for exactly the first BUSY cycle, with mem_addr, mem_wr (d_wr for data, 0 for instruction) and mem_wdata registered from the winner's inputs on the granting edge.
REQ-020 A 4-bit counter SHALL load MEM_LAT-1 on the granting edge and decrement each BUSY cycle; done SHALL pulse in the BUSY cycle where the counter is 0, i.e. MEM_LAT cycles after the mem_en cycle.
REQ-021 The done pulse SHALL go only to the owner: i_done in I_BUSY, d_done in D_BUSY. Never both; never outside BUSY.
REQ-022 In the done cycle, the FSM SHALL re-arbitrate on the edge. The other requester, if its req is high, SHALL be granted directly with no idle cycle. Otherwise the FSM returns to IDLE. The owner's still-high req SHALL be ignored in this cycle.
REQ-023 A req that drops mid-transaction SHALL NOT abort it. The done pulse still fires.
REQ-024 Inputs changing during BUSY SHALL NOT alter mem_addr, mem_wr or mem_wdata.
REQ-025 stall_if = i_req & ~i_done, and stall_mem = d_req & ~d_done, combinationally.
REQ-026 A simultaneous i_req and d_req arriving in IDLE SHALL serve data first, then instruction back-to-back. Total i_done latency is 2*(MEM_LAT+1) cycles from the request.

Reset
REQ-027 While rst is low, the block SHALL be in state IDLE, with counter 0, mem_en, mem_wr, i_done and d_done all 0, and mem_addr and mem_wdata at 16'h0000.
REQ-028 Reset asserted mid-transaction SHALL abandon the access with no done pulse. The first grant SHALL occur on the first rising edge after rst deasserts with a request pending.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN defined: a 1-bit last-owner register (reset value 1 = data) SHALL be added. On a tie in IDLE, the requester that was not the last owner wins.
REQ-030 Macro ARB_ROUND_ROBIN_EN undefined: fixed data priority per REQ-018. The last-owner register SHALL be absent.
REQ-031 Single-requester timing SHALL be identical in both builds.

Verification (MEM_LAT=4)
REQ-032 i_req=1, i_addr=16'h0040 at cycle 0:
- mem_en=1 and mem_addr=16'h0040 in cycle 1.
- i_done=1 and rdata=mem_rdata in cycle 5.
- stall_if=1 in cycles 0-4.
REQ-033 d_req=1, d_wr=1, d_addr=16'h1000, d_wdata=16'hBEEF:
- mem_wr=1 and mem_wdata=16'hBEEF in the mem_en cycle.
- d_done 4 cycles later.
- i_done stays 0.
REQ-034 i_req and d_req both raised in cycle 0:
- d_done in cycle 5.
- Instruction mem_en in cycle 6.
- i_done in cycle 10.
- With ARB_ROUND_ROBIN_EN, after a prior data service: instruction is served first.
REQ-035 i_req pulsed for 1 cycle only: the access completes and i_done still pulses in cycle 5. The FSM then returns to IDLE.
REQ-036 rst driven low in cycle 3 of a D_BUSY access:
- All outputs return to their reset values immediately.
- No d_done occurs.
- Re-raising d_req after release gives a fresh mem_en one cycle later.
